// File: rtl/mmio_ram_ctrl_pkg.sv
// Shared address-map helpers and input-channel mode encoding for the MMIO RAM controller.
package mmio_ram_ctrl_pkg;

    localparam bit OVW_STRICT  = 1'b0;
    localparam bit OVW_REPLACE = 1'b1;

    function automatic int status_addr(input int io_base);
        return io_base - 1;
    endfunction

    function automatic int in_addr(input int io_base, input int k);
        return io_base + k;
    endfunction

    function automatic int out_addr(input int io_base, input int n_in, input int j);
        return io_base + n_in + j;
    endfunction

endpackage

// File: rtl/mmio_in_channel.sv
// One device-input channel: a capture register plus a fresh flag driving valid/ready.
module mmio_in_channel
    import mmio_ram_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter bit OVERWRITE = OVW_STRICT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic          rd_clr,
    output logic          ready,
    output logic [DW-1:0] q,
    output logic          fresh
);

    logic [DW-1:0] r_q;
    logic          r_fresh;
    logic          w_xfer;

    // In strict mode unread data back-pressures the device
    assign ready  = (OVERWRITE == OVW_REPLACE) ? !reset : (!r_fresh && !reset);
    assign w_xfer = valid && ready;
    assign q      = r_q;
    assign fresh  = r_fresh;

    // Capture register and fresh flag; a new transfer wins over a same-edge CPU read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_fresh <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_q <= data;
            end
            if (w_xfer) begin
                r_fresh <= 1'b1;
            end else if (rd_clr) begin
                r_fresh <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_ram_ctrl.sv
// Data RAM with a memory-mapped IO window: device-input channels, device-output registers and a STATUS word.
module mmio_ram_ctrl
    import mmio_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 4096,
    parameter int N_IN          = 5,
    parameter int N_OUT         = 5,
    parameter int IO_BASE       = 4086,
    parameter bit OVERWRITE     = OVW_STRICT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wEn,
    input  logic [ADDRESS_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]       dataIn,
    output logic [DATA_WIDTH-1:0]       dataOut,
    input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [N_IN-1:0]             in_valid,
    output logic [N_IN-1:0]             in_ready,
    output logic [N_OUT*DATA_WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]            out_update
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0]          r_mem [DEPTH];
    logic [DW-1:0]          r_data_out;
    logic [N_OUT*DW-1:0]    r_out_data;
    logic [N_OUT-1:0]       r_out_update;

    logic [DW-1:0]          w_in_q [N_IN];
    logic [N_IN-1:0]        w_fresh;
    logic [N_IN-1:0]        w_in_hit;
    logic [N_IN-1:0]        w_rd_clr;
    logic [N_OUT-1:0]       w_out_hit;
    logic                   w_is_status;
    logic                   w_is_ram;
    logic [DW-1:0]          w_status;
    logic [DW-1:0]          w_in_sel;
    logic [DW-1:0]          w_out_sel;
    logic [DW-1:0]          w_rd_data;

    assign w_is_status = (addr == ADDRESS_WIDTH'(status_addr(IO_BASE)));
    assign w_is_ram    = !w_is_status && !(|w_in_hit) && !(|w_out_hit);
    assign w_rd_clr    = w_in_hit & {N_IN{!wEn}};

    genvar gk;
    generate
        for (gk = 0; gk < N_IN; gk++) begin : g_in
            assign w_in_hit[gk] = (addr == ADDRESS_WIDTH'(in_addr(IO_BASE, gk)));

            mmio_in_channel #(
                .DW        (DW),
                .OVERWRITE (OVERWRITE)
            ) u_ch (
                .clk    (clk),
                .reset  (reset),
                .valid  (in_valid[gk]),
                .data   (in_data[gk*DW +: DW]),
                .rd_clr (w_rd_clr[gk]),
                .ready  (in_ready[gk]),
                .q      (w_in_q[gk]),
                .fresh  (w_fresh[gk])
            );
        end
        for (gk = 0; gk < N_OUT; gk++) begin : g_out_hit
            assign w_out_hit[gk] = (addr == ADDRESS_WIDTH'(out_addr(IO_BASE, N_IN, gk)));
        end
    endgenerate

    // One-hot selects are OR-reduced so the read mux needs no priority among channels
    always_comb begin
        w_status = '0;
        w_status[N_IN-1:0] = w_fresh;
        w_in_sel  = '0;
        w_out_sel = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_in_sel = w_in_sel | ({DW{w_in_hit[k]}} & w_in_q[k]);
        end
        for (int j = 0; j < N_OUT; j++) begin
            w_out_sel = w_out_sel | ({DW{w_out_hit[j]}} & r_out_data[j*DW +: DW]);
        end
        if (w_is_status) begin
            w_rd_data = w_status;
        end else if (|w_in_hit) begin
            w_rd_data = w_in_sel;
        end else if (|w_out_hit) begin
            w_rd_data = w_out_sel;
        end else begin
            w_rd_data = r_mem[addr];
        end
    end

    // RAM array write port; left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wEn && w_is_ram) begin
            r_mem[addr] <= dataIn;
        end
    end

    // Registered read data; write cycles hold the previous value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (!wEn) begin
            r_data_out <= w_rd_data;
        end
    end

    // Output registers and their one-cycle update strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data   <= '0;
            r_out_update <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                r_out_update[j] <= wEn && w_out_hit[j];
                if (wEn && w_out_hit[j]) begin
                    r_out_data[j*DW +: DW] <= dataIn;
                end
            end
        end
    end

    assign dataOut    = r_data_out;
    assign out_data   = r_out_data;
    assign out_update = r_out_update;

endmodule
